// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state encoding, response status codes and bus width defaults
package apb_pkg;

    localparam int DATASIZE_DEF = 32;
    localparam int ADDRSIZE_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // {timeout, err}; a timeout always reports as an error too
    localparam logic [1:0] RSP_OKAY    = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts wait-state cycles and flags the cycle that reaches the TIMEOUT limit
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    // saturating wait counter, pinned at zero when the timeout is disabled
    always_ff @(posedge PCLK or posedge PRESET)
        if (PRESET) cnt <= '0;
        else if (clr || TIMEOUT == 0) cnt <= '0;
        else if (en && cnt != MAX) cnt <= cnt + 1'b1;

    // the current waiting cycle is the TIMEOUT-th one
    assign expired = (TIMEOUT != 0) && en && cnt == LAST;

endmodule

// File: rtl/apb_master.sv
// apb_master: valid/ready command to APB SETUP/ACCESS requester with wait-state timeout
module apb_master
    import apb_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int TIMEOUT  = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDRSIZE-1:0] cmd_addr,
    input  logic [DATASIZE-1:0] cmd_wdata,
    output logic                rsp_valid,
    output logic [DATASIZE-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDRSIZE-1:0] PADDR,
    output logic [DATASIZE-1:0] PWDATA,
    input  logic [DATASIZE-1:0] PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    apb_state_t state, state_nxt;
    logic [1:0] status;
    logic       hs, done, abort, wait_clr, wait_en;

    // completer inputs only matter in ACCESS; the state term masks them elsewhere
    assign hs       = cmd_valid && cmd_ready;
    assign done     = state == ACCESS && PREADY;
    assign wait_clr = state == SETUP;
    assign wait_en  = state == ACCESS && !PREADY;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clr     (wait_clr),
        .en      (wait_en),
        .expired (abort)
    );

    // state register
    always_ff @(posedge PCLK or posedge PRESET)
        if (PRESET) state <= IDLE;
        else state <= state_nxt;

    // next state: accept in IDLE or on completion, one SETUP cycle, ACCESS until ready or abort
    always_comb begin
        state_nxt = state == IDLE  ? (cmd_valid ? SETUP : IDLE)
                  : state == SETUP ? ACCESS
                  : done           ? (cmd_valid ? SETUP : IDLE)
                  : abort          ? IDLE
                  :                  ACCESS;
    end

    // bus phase strobes and command acceptance decoded from state
    always_comb begin
        PSEL      = state != IDLE;
        PENABLE   = state == ACCESS;
        cmd_ready = !PRESET && (state == IDLE || done);
    end

    // capture the command at SETUP entry; it stays put for the whole transfer
    always_ff @(posedge PCLK or posedge PRESET)
        if (PRESET) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (hs) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
        end

    // single-cycle response after a completed or aborted ACCESS
    always_ff @(posedge PCLK or posedge PRESET)
        if (PRESET) begin
            rsp_valid <= 1'b0;
            status    <= RSP_OKAY;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= done || abort;
            status    <= done ? (PSLVERR ? RSP_SLVERR : RSP_OKAY) : abort ? RSP_TIMEOUT : RSP_OKAY;
            rsp_rdata <= (done && !PWRITE && !PSLVERR) ? PRDATA : '0;
        end

    assign rsp_err     = status[0];
    assign rsp_timeout = status[1];

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: cycle-timeline model of APB transfers checked every cycle, plus literal pins
module tb_apb_master;

    localparam int TO = 16;
    localparam int NC = 1024;

    logic        PCLK = 0, PRESET = 1;
    logic        cmd_valid = 0, cmd_write = 0;
    logic [31:0] cmd_addr = 0, cmd_wdata = 0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA = 0;
    logic        PREADY = 0, PSLVERR = 0;

    apb_master #(.DATASIZE(32), .ADDRSIZE(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0, failures = 0, cyc = 0;
    int rv_seen = 0, rv_exp = 0;
    int m_n;
    bit m_rv;
    bit x_mode = 0, acc_now = 0;
    int nxt_wait = 0;
    bit nxt_err = 0;

    // expected bus picture per cycle, filled in when a command is accepted
    bit          e_psel[NC], e_pen[NC], e_busy[NC], e_rv[NC], e_err[NC], e_to[NC], e_write[NC];
    logic [31:0] e_addr[NC], e_wdata[NC], e_rdata[NC];

    bit          cur_act = 0, cur_to, cur_write, cur_err;
    int          cur_end;
    logic [31:0] cur_addr, cur_wdata;
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endfunction

    // completer: ready only on the planned last ACCESS cycle, noise everywhere else
    task automatic edge_drive();
        @(posedge PCLK);
        cyc++;
        #1;
        if (cur_act && e_pen[cyc]) begin
            PREADY  = (cyc == cur_end) && !cur_to;
            PSLVERR = PREADY ? cur_err : 1'($urandom);
            PRDATA  = (PREADY && !cur_write) ? mem_rd(cur_addr) : $urandom;
        end else if (x_mode) begin
            PREADY  = 'x;
            PSLVERR = 'x;
            PRDATA  = 'x;
        end else begin
            PREADY  = 1'($urandom);
            PSLVERR = 1'($urandom);
            PRDATA  = $urandom;
        end
    endtask

    // compare against the timeline, then advance the model for this cycle
    task automatic sample();
        @(negedge PCLK);
        acc_now = 0;
        if (PRESET) begin
            chk("rst_psel", PSEL, 0);
            chk("rst_penable", PENABLE, 0);
            chk("rst_pwrite", PWRITE, 0);
            chk("rst_paddr", PADDR, 0);
            chk("rst_pwdata", PWDATA, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_rsp_timeout", rsp_timeout, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
            for (int k = cyc; k < NC; k++) begin
                e_psel[k] = 0; e_pen[k] = 0; e_busy[k] = 0; e_rv[k] = 0;
                e_err[k] = 0; e_to[k] = 0; e_write[k] = 0;
                e_addr[k] = 0; e_wdata[k] = 0; e_rdata[k] = 0;
            end
            cur_act = 0;
            return;
        end
        chk("cmd_ready", cmd_ready, !e_busy[cyc]);
        chk("psel", PSEL, e_psel[cyc]);
        chk("penable", PENABLE, e_pen[cyc]);
        chk("rsp_valid", rsp_valid, e_rv[cyc]);
        if (rsp_valid) rv_seen++;
        if (e_psel[cyc]) begin
            chk("paddr", PADDR, e_addr[cyc]);
            chk("pwrite", PWRITE, e_write[cyc]);
            chk("pwdata", PWDATA, e_wdata[cyc]);
        end
        if (e_rv[cyc]) begin
            rv_exp++;
            chk("rsp_err", rsp_err, e_err[cyc]);
            chk("rsp_timeout", rsp_timeout, e_to[cyc]);
            chk("rsp_rdata", rsp_rdata, e_rdata[cyc]);
        end
        if (cur_act && cyc == cur_end) begin
            if (!cur_to) begin
                if (!cur_write) e_rdata[cyc+1] = cur_err ? 32'h0 : mem_rd(cur_addr);
                else if (!cur_err) mem[cur_addr] = cur_wdata;
            end
            cur_act = 0;
        end
        if (cmd_valid && !e_busy[cyc]) begin
            acc_now   = 1;
            cur_act   = 1;
            cur_to    = nxt_wait >= TO;
            cur_end   = cur_to ? cyc + 1 + TO : cyc + 2 + nxt_wait;
            cur_write = cmd_write;
            cur_addr  = cmd_addr;
            cur_wdata = cmd_wdata;
            cur_err   = nxt_err;
            for (int k = cyc + 1; k <= cur_end; k++) begin
                e_psel[k]  = 1;
                e_pen[k]   = k >= cyc + 2;
                e_busy[k]  = cur_to || k < cur_end;
                e_addr[k]  = cur_addr;
                e_write[k] = cur_write;
                e_wdata[k] = cur_wdata;
            end
            e_rv[cur_end+1]    = 1;
            e_err[cur_end+1]   = cur_to || cur_err;
            e_to[cur_end+1]    = cur_to;
            e_rdata[cur_end+1] = 0;
        end
    endtask

    task automatic issue(bit w, logic [31:0] a, logic [31:0] d, int wt, bit er);
        bit ok = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        nxt_wait = wt; nxt_err = er;
        for (int i = 0; i < 200; i++) begin
            sample();
            if (acc_now) begin
                ok = 1;
                break;
            end
            edge_drive();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_bound cycle=%0d actual=no_accept required=accept", cyc);
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            edge_drive();
            cmd_valid = 0;
            sample();
        end
    endtask

    task automatic measure(output int n, output bit rv);
        n = 0;
        rv = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (PENABLE) n++;
            if (rsp_valid) begin
                rv = 1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) begin edge_drive(); sample(); end
        edge_drive(); PRESET = 0; sample();
        idle(2);

        // zero-wait write
        edge_drive(); issue(1, 32'h10, 32'hDEADBEEF, 0, 0);
        idle(1); chk("t1_psel", PSEL, 1); chk("t1_setup_pen", PENABLE, 0);
        idle(1); chk("t1_access_pen", PENABLE, 1);
        idle(1); chk("t1_rsp_valid", rsp_valid, 1); chk("t1_rsp_err", rsp_err, 0);

        // read back
        edge_drive(); issue(0, 32'h10, 32'h0, 0, 0);
        idle(1); chk("t2_setup_addr", PADDR, 32'h10); chk("t2_setup_wr", PWRITE, 0);
        idle(1); chk("t2_access_addr", PADDR, 32'h10); chk("t2_access_wr", PWRITE, 0);
        idle(1); chk("t2_rsp_valid", rsp_valid, 1); chk("t2_rdata", rsp_rdata, 32'hDEADBEEF);

        // three wait states
        edge_drive(); issue(1, 32'h30, 32'hA5A50003, 3, 0);
        measure(m_n, m_rv);
        chk("t3_access_cycles", m_n, 4); chk("t3_rsp_seen", m_rv, 1);

        // timeout
        edge_drive(); issue(0, 32'h40, 32'h0, 100, 0);
        measure(m_n, m_rv);
        chk("t4_access_cycles", m_n, 16); chk("t4_rsp_seen", m_rv, 1);
        chk("t4_err", rsp_err, 1); chk("t4_timeout", rsp_timeout, 1);
        chk("t4_rdata", rsp_rdata, 0); chk("t4_psel", PSEL, 0);

        // slave error on read, then back-to-back writes
        mem[32'h20] = 32'h1234;
        edge_drive(); issue(0, 32'h20, 32'h0, 0, 1);
        idle(3); chk("t5_rsp_valid", rsp_valid, 1); chk("t5_err", rsp_err, 1); chk("t5_rdata", rsp_rdata, 0);
        edge_drive(); issue(1, 32'h50, 32'h5555AAAA, 0, 0);
        edge_drive(); issue(1, 32'h54, 32'h00005454, 1, 0);
        idle(1); chk("t5_b2b_psel", PSEL, 1); chk("t5_b2b_pen", PENABLE, 0);
        chk("t5_b2b_addr", PADDR, 32'h54); chk("t5_b2b_rsp", rsp_valid, 1);
        idle(1); chk("t5_b2b_access", PENABLE, 1);
        idle(3);
        edge_drive(); issue(0, 32'h50, 32'h0, 2, 0);
        idle(5); chk("t5_readback", rsp_rdata, 32'h5555AAAA);

        // reset in the middle of ACCESS, then X on completer inputs while idle
        edge_drive(); issue(0, 32'h10, 32'h0, 5, 0);
        idle(2);
        edge_drive(); cmd_valid = 0; #2 PRESET = 1; #1;
        chk("t6_async_psel", PSEL, 0); chk("t6_async_pen", PENABLE, 0); chk("t6_async_rv", rsp_valid, 0);
        sample();
        edge_drive(); sample();
        edge_drive(); PRESET = 0; x_mode = 1; sample();
        idle(4); chk("t6_x_psel", PSEL, 0); chk("t6_x_ready", cmd_ready, 1);
        x_mode = 0;
        edge_drive(); issue(0, 32'h10, 32'h0, 0, 0);
        idle(3); chk("t6_after_rdata", rsp_rdata, 32'hDEADBEEF);
        idle(2);
        chk("rsp_count", rv_seen, rv_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (initiator) that drives the PSEL/PENABLE/PADDR/PWRITE/PWDATA bus towards one or more APB completers.
- Converts a simple valid/ready command interface from local logic into APB SETUP/ACCESS phases.
- Supports completer wait states and PSLVERR.
- Bounds every access with a wait-state timeout and returns read data and status on a single-cycle response strobe.

Parameters:
- DATASIZE, 32, width of PWDATA/PRDATA and command/response data.
- ADDRSIZE, 32, width of PADDR and command address.
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRSIZE  transfer address.
- cmd_wdata  in  DATASIZE  write data.
- rsp_valid  out  1  one-cycle pulse, transfer finished.
- rsp_rdata  out  DATASIZE  read data; 0 for writes and on error/timeout.
- rsp_err  out  1  PSLVERR or timeout; valid with rsp_valid.
- rsp_timeout  out  1  timeout abort; valid with rsp_valid.
- PSEL  out  1  completer select.
- PENABLE  out  1  ACCESS-phase marker.
- PWRITE  out  1  transfer direction.
- PADDR  out  ADDRSIZE  address.
- PWDATA  out  DATASIZE  write data.
- PRDATA  in  DATASIZE  read data from completer.
- PREADY  in  1  completer ready.
- PSLVERR  in  1  completer error.

Behaviour:
- Reset (async, PRESET=1): state IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout = 0.
  - PADDR, PWDATA, rsp_rdata = 0.
  - cmd_ready = 0 while PRESET is high.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1 (combinational on state).
  - On handshake: latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA, PSEL <= 1, go to SETUP.
- SETUP (exactly one cycle): PSEL = 1, PENABLE = 0. Next: ACCESS with PENABLE <= 1; clear the wait counter.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PADDR/PWRITE/PWDATA held stable for the whole transfer.
  - PREADY, PRDATA and PSLVERR are sampled only in ACCESS. Their values in any other state, including X, are ignored and must not affect state.
  - PREADY = 1: transfer completes in this cycle.
    - Next cycle: rsp_valid = 1, rsp_err = PSLVERR, rsp_timeout = 0.
    - rsp_rdata = PRDATA for reads with PSLVERR=0, else 0.
    - PENABLE <= 0.
  - PREADY = 0: wait counter increments. When it reaches TIMEOUT (TIMEOUT != 0), abort.
    - PSEL <= 0, PENABLE <= 0.
    - Next cycle: rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
    - Go to IDLE.
  - Counter width is clog2(TIMEOUT+1). Counter saturates and is held at 0 when TIMEOUT = 0.
- Zero-wait latency: handshake cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3.
- Back-to-back transfers:
  - cmd_ready is also 1 in ACCESS during the cycle PREADY = 1.
  - If a command is accepted then, go directly to SETUP: PSEL stays 1, PENABLE <= 0, new address and data loaded.
  - Otherwise go to IDLE with PSEL <= 0.
  - cmd_ready = 0 in SETUP and in ACCESS while PREADY = 0.
- Responses have no backpressure; rsp_valid is high for exactly one cycle per accepted command.
- Reset mid-transfer: bus returns to idle immediately (async); no response is issued for the aborted transfer.
- PSEL is never high with the address or data changing except across a SETUP entry.

Decomposition:
- Package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS};
  - localparams for response status encoding;
  - shared DATASIZE/ADDRSIZE defaults, so the existing completer model and this block agree.
- One sub-module, apb_wait_timer:
  - wait counter with clear, enable and expired outputs;
  - parameterised by TIMEOUT, so it is reusable by future completers.

Test Plan:
1. Write 0xDEADBEEF to 0x10 against a zero-wait completer: PSEL rises cycle N+1, PENABLE cycle N+2, rsp_valid cycle N+3, rsp_err = 0.
2. Read back 0x10: rsp_rdata = 0xDEADBEEF at N+3; PADDR and PWRITE stable across SETUP and ACCESS.
3. Completer inserts 3 wait states: ACCESS lasts 4 cycles, bus signals held stable, rsp_valid one cycle after PREADY, cmd_ready low during the waits.
4. PREADY held 0 with TIMEOUT = 16: abort after 16 ACCESS cycles; rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; PSEL returns to 0.
5. PSLVERR = 1 on a read of 0x20 returning 0x1234: rsp_err = 1, rsp_rdata = 0. Follow with two back-to-back commands: PSEL stays high and PENABLE drops for exactly one SETUP cycle between them.
6. Assert PRESET during ACCESS: PSEL, PENABLE and rsp_valid go to 0 asynchronously. After release, PREADY driven X outside ACCESS causes no state change.
